// File: rtl/boot_imem.sv
// Writable instruction memory: a byte-stream loader fills little-endian words while
// the core is held off, and fetch keeps a registered-address, one-cycle read.
module boot_imem #(
   parameter int unsigned       DATA_W     = 32,
   parameter int unsigned       DEPTH_LOG2 = 12,
   parameter logic [29:0]       RESET_ADDR = 30'd0,
   parameter logic [DATA_W-1:0] NOP_WORD   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [29:0]           fetch_addr,
   input  logic                  fetch_en,
   output logic [DATA_W-1:0]     inst,
   output logic                  inst_valid,
   output logic                  addr_err,
   input  logic                  load_start,
   input  logic [DEPTH_LOG2:0]   load_len,
   input  logic [7:0]            ld_byte,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   output logic                  load_busy,
   output logic                  load_done
);

   localparam int unsigned BYTES = DATA_W / 8;
   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
   localparam int unsigned LW    = DEPTH_LOG2 + 1;
   localparam int unsigned BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [LW-1:0] DEPTH_W = LW'(DEPTH);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [29:0]       addr_q, addr_d;
   logic [LW-1:0]     wptr_q, wptr_d;
   logic [LW-1:0]     len_q, len_d;
   logic [BCW-1:0]    bcnt_q, bcnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              valid_q;
   logic              we;

   logic [DATA_W-1:0] mem [DEPTH];

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wptr_d  = wptr_q;
      len_d   = len_q;
      bcnt_d  = bcnt_q;
      shift_d = shift_q;
      we      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (fetch_en) begin
               addr_d = fetch_addr;
            end
            if (load_start && (load_len != '0)) begin
               state_d = ST_LOAD;
               wptr_d  = '0;
               bcnt_d  = '0;
               len_d   = (load_len > DEPTH_W) ? DEPTH_W : load_len;
            end
         end
         ST_LOAD: begin
            if (ld_valid) begin
               for (int k = 0; k < BYTES; k++) begin
                  if (bcnt_q == BCW'(k)) begin
                     shift_d[8*k +: 8] = ld_byte;
                  end
               end
               // Final lane: write the assembled word on this same edge.
               if (bcnt_q == BCW'(BYTES - 1)) begin
                  we     = 1'b1;
                  bcnt_d = '0;
                  wptr_d = wptr_q + LW'(1);
                  if (wptr_d == len_q) begin
                     state_d = ST_DONE;
                  end
               end else begin
                  bcnt_d = bcnt_q + BCW'(1);
               end
            end
         end
         ST_DONE: begin
            addr_d  = RESET_ADDR;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Memory contents survive reset, so the array has no reset branch.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wptr_q[DEPTH_LOG2-1:0]] <= shift_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         addr_q  <= RESET_ADDR;
         wptr_q  <= '0;
         len_q   <= '0;
         bcnt_q  <= '0;
         shift_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wptr_q  <= wptr_d;
         len_q   <= len_d;
         bcnt_q  <= bcnt_d;
         shift_q <= shift_d;
         valid_q <= (state_d == ST_IDLE);
      end
   end

   assign addr_err   = |addr_q[29:DEPTH_LOG2];
   assign inst_valid = valid_q;
   assign inst       = (valid_q && !addr_err) ? mem[addr_q[DEPTH_LOG2-1:0]] : NOP_WORD;
   assign ld_ready   = (state_q == ST_LOAD);
   assign load_busy  = (state_q == ST_LOAD);
   assign load_done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_boot_imem.sv
// Directed bench for boot_imem: load/fetch vectors, stalls, handshake gaps, bounds, reset.
module tb_boot_imem;

   localparam int DEPTH = 4096;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [29:0] fetch_addr;
   logic        fetch_en;
   logic [31:0] inst;
   logic        inst_valid;
   logic        addr_err;
   logic        load_start;
   logic [12:0] load_len;
   logic [7:0]  ld_byte;
   logic        ld_valid;
   logic        ld_ready;
   logic        load_busy;
   logic        load_done;

   int nvec = 0;
   int nerr = 0;
   int dc;
   logic [7:0] bq[$];

   typedef struct {
      logic        en;
      logic [29:0] addr;
      logic [31:0] inst;
      logic        err;
   } vec_t;
   vec_t tbl[8];

   boot_imem dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fetch_addr (fetch_addr),
      .fetch_en   (fetch_en),
      .inst       (inst),
      .inst_valid (inst_valid),
      .addr_err   (addr_err),
      .load_start (load_start),
      .load_len   (load_len),
      .ld_byte    (ld_byte),
      .ld_valid   (ld_valid),
      .ld_ready   (ld_ready),
      .load_busy  (load_busy),
      .load_done  (load_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %08h, want %08h", name, act, exp);
      end
   endtask

   task automatic push_word(input logic [31:0] w);
      for (int k = 0; k < 4; k++) bq.push_back(w[8*k +: 8]);
   endtask

   function automatic logic [31:0] gen_word(input int i);
      logic [15:0] v;
      v = 16'(i);
      return {~v, v};
   endfunction

   task automatic start_load(input int len);
      load_len   = 13'(len);
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      chk("start_busy", 32'(load_busy), 32'd1);
      chk("start_ready", 32'(ld_ready), 32'd1);
      chk("start_valid", 32'(inst_valid), 32'd0);
   endtask

   // Streams bq into the loader; restart_at pulses load_start mid-load.
   task automatic feed(input int gap_pct, input int restart_at, output int done_cnt);
      int   idx;
      int   cyc;
      logic acc;
      idx      = 0;
      cyc      = 0;
      done_cnt = 0;
      while (idx < bq.size() && cyc < 40000) begin
         ld_byte    = bq[idx];
         ld_valid   = (gap_pct == 0) ? 1'b1 : ($urandom_range(99) >= gap_pct);
         load_start = (idx == restart_at);
         load_len   = 13'd1;
         acc        = ld_valid && ld_ready;
         step();
         cyc++;
         if (load_done) done_cnt++;
         if (acc) idx++;
      end
      load_start = 1'b0;
      ld_valid   = 1'b0;
      chk("feed_bytes_accepted", 32'(idx), 32'(bq.size()));
   endtask

   task automatic fetch(input logic [29:0] a, input logic [31:0] exp, input string name);
      fetch_en   = 1'b1;
      fetch_addr = a;
      step();
      fetch_en   = 1'b0;
      chk(name, inst, exp);
   endtask

   initial begin
      logic [7:0] rb [6];
      rb = '{8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'hAA, 8'h55};
      fetch_en   = 1'b0;
      fetch_addr = '0;
      load_start = 1'b0;
      load_len   = '0;
      ld_byte    = '0;
      ld_valid   = 1'b0;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_inst", inst, 32'h0);
      chk("rst_valid", 32'(inst_valid), 32'd0);
      chk("rst_err", 32'(addr_err), 32'd0);
      chk("rst_ready", 32'(ld_ready), 32'd0);
      chk("rst_busy", 32'(load_busy), 32'd0);
      chk("rst_done", 32'(load_done), 32'd0);
      rst_n = 1'b1;
      chk("post_rel_valid", 32'(inst_valid), 32'd0);
      chk("post_rel_inst", inst, 32'h0);
      step();
      chk("first_edge_valid", 32'(inst_valid), 32'd1);

      // Basic load of three words
      bq = '{8'h00, 8'h00, 8'h1d, 8'h3c, 8'h03, 8'h14, 8'h00, 8'h0c,
             8'h00, 8'h70, 8'hbd, 8'h37};
      start_load(3);
      feed(0, -1, dc);
      chk("basic_done_pulses", 32'(dc), 32'd1);
      chk("basic_done_now", 32'(load_done), 32'd1);
      chk("basic_done_ready", 32'(ld_ready), 32'd0);
      chk("basic_done_valid", 32'(inst_valid), 32'd0);
      step();
      chk("basic_done_clear", 32'(load_done), 32'd0);
      chk("basic_idle_valid", 32'(inst_valid), 32'd1);
      chk("basic_first_fetch", inst, 32'h3c1d0000);

      // Fetch, stall and out-of-range vectors
      tbl[0] = '{1'b1, 30'd0,      32'h3c1d0000, 1'b0};
      tbl[1] = '{1'b1, 30'd1,      32'h0c001403, 1'b0};
      tbl[2] = '{1'b1, 30'd2,      32'h37bd7000, 1'b0};
      tbl[3] = '{1'b0, 30'd0,      32'h37bd7000, 1'b0};
      tbl[4] = '{1'b0, 30'd1,      32'h37bd7000, 1'b0};
      tbl[5] = '{1'b1, 30'h1000,   32'h00000000, 1'b1};
      tbl[6] = '{1'b1, 30'h3fffffff, 32'h00000000, 1'b1};
      tbl[7] = '{1'b1, 30'd1,      32'h0c001403, 1'b0};
      for (int i = 0; i < 8; i++) begin
         fetch_en   = tbl[i].en;
         fetch_addr = tbl[i].addr;
         step();
         chk($sformatf("vec%0d_inst", i), inst, tbl[i].inst);
         chk($sformatf("vec%0d_err", i), 32'(addr_err), 32'(tbl[i].err));
      end
      fetch_en = 1'b0;

      // Two-word load with random gaps and an ignored load_start mid-load
      bq.delete();
      push_word(32'hDEADBEEF);
      push_word(32'h01234567);
      start_load(2);
      feed(40, 3, dc);
      chk("hs_done_pulses", 32'(dc), 32'd1);
      chk("hs_done_now", 32'(load_done), 32'd1);
      ld_valid = 1'b1;
      ld_byte  = 8'hEE;
      chk("hs_ready_in_done", 32'(ld_ready), 32'd0);
      step();
      chk("hs_ready_in_idle", 32'(ld_ready), 32'd0);
      chk("hs_busy_in_idle", 32'(load_busy), 32'd0);
      chk("hs_word0", inst, 32'hDEADBEEF);
      ld_valid = 1'b0;
      fetch(30'd1, 32'h01234567, "hs_word1");

      // Reset after 6 of 8 bytes
      load_len = 13'd2;
      start_load(2);
      for (int k = 0; k < 6; k++) begin
         ld_byte  = rb[k];
         ld_valid = 1'b1;
         step();
         chk($sformatf("rml_nodone%0d", k), 32'(load_done), 32'd0);
      end
      ld_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("rml_busy", 32'(load_busy), 32'd0);
      chk("rml_ready", 32'(ld_ready), 32'd0);
      chk("rml_done", 32'(load_done), 32'd0);
      chk("rml_valid", 32'(inst_valid), 32'd0);
      chk("rml_inst", inst, 32'h0);
      step();
      rst_n = 1'b1;
      fetch(30'd0, 32'hCAFEF00D, "rml_word0");
      fetch(30'd1, 32'h01234567, "rml_word1");

      // load_len = 0 is ignored
      load_len   = 13'd0;
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      chk("len0_busy", 32'(load_busy), 32'd0);
      chk("len0_ready", 32'(ld_ready), 32'd0);
      chk("len0_valid", 32'(inst_valid), 32'd1);
      chk("len0_inst", inst, 32'h01234567);

      // Oversized load clamps to DEPTH words
      bq.delete();
      for (int i = 0; i < DEPTH; i++) push_word(gen_word(i));
      start_load(DEPTH + 5);
      feed(0, -1, dc);
      chk("big_done_pulses", 32'(dc), 32'd1);
      chk("big_done_now", 32'(load_done), 32'd1);
      step();
      chk("big_word0", inst, gen_word(0));
      chk("big_ready_after", 32'(ld_ready), 32'd0);
      fetch(30'd4095, gen_word(4095), "big_word4095");
      fetch(30'd2048, gen_word(2048), "big_word2048");
      fetch(30'd1, gen_word(1), "big_word1");
      fetch(30'h1000, 32'h0, "big_oor");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/boot_imem.md
# boot_imem

Parametrised, writable instruction memory for the MIPS core. It replaces the fixed per-application instruction ROM, so one bitstream can run any program. A byte-stream loader port (fed by the UART receive path) fills the memory with little-endian words while the core is held off. The fetch side keeps the registered-address, one-cycle fetch timing the core's IF stage already expects.

## Interface
Parameters:
- DATA_W, 32, instruction width in bits; must be a multiple of 8 (BYTES = DATA_W/8)
- DEPTH_LOG2, 12, log2 of memory depth in words (DEPTH = 2**DEPTH_LOG2)
- RESET_ADDR, 0, word address loaded into the fetch address register on reset and after every completed load
- NOP_WORD, 32'h00000000, word driven on inst when fetch is invalid or out of range

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- fetch_addr  in  30  word address from the core PC (PC[31:2])
- fetch_en  in  1  1 = capture fetch_addr this edge; 0 = hold (stall)
- inst  out  DATA_W  instruction at the registered address
- inst_valid  out  1  inst is a real fetch result
- addr_err  out  1  registered address is outside 0..DEPTH-1
- load_start  in  1  request a program load (sampled only in IDLE)
- load_len  in  DEPTH_LOG2+1  number of words to load
- ld_byte  in  8  loader data byte
- ld_valid  in  1  ld_byte is valid
- ld_ready  out  1  block accepts a byte this cycle
- load_busy  out  1  FSM is in LOAD
- load_done  out  1  one-cycle pulse when a load completes

## Operation
- Memory: DEPTH x DATA_W. Contents are undefined at power-up and are never cleared by reset.
- Fetch register addr_r:
  - Async reset to RESET_ADDR.
  - On an edge with fetch_en=1 and state IDLE, addr_r <= fetch_addr.
  - Otherwise addr_r holds.
- inst:
  - If inst_valid=0 or addr_err=1: inst = NOP_WORD.
  - Otherwise: inst = mem[addr_r[DEPTH_LOG2-1:0]].
- addr_err = |addr_r[29:DEPTH_LOG2], evaluated from the registered address.
- inst_valid:
  - 0 in reset, in LOAD, and in DONE.
  - Otherwise 1 from the first edge after reset release.
- Loader FSM states are IDLE, LOAD and DONE.
  - IDLE -> LOAD when load_start=1 and load_len != 0. On entry: wptr=0, bcnt=0, len_r=min(load_len, DEPTH). load_len=0 is ignored.
  - LOAD: ld_ready=1 and load_busy=1.
    - Each accepted byte (ld_valid & ld_ready) goes into lane bcnt of the shift word (byte 0 -> bits [7:0]), then bcnt increments.
    - On the byte with bcnt = BYTES-1: write the assembled word to mem[wptr], wptr increments, bcnt wraps to 0.
    - Once the written-word count equals len_r, go to DONE.
  - DONE (exactly 1 cycle): load_done=1, ld_ready=0, addr_r <= RESET_ADDR. Then return to IDLE.
- load_start is ignored outside IDLE.
- ld_valid without ld_ready is ignored; no byte is consumed.
- fetch_en is ignored in LOAD and DONE; addr_r does not follow fetch_addr in those states.
- Reset mid-load: FSM returns to IDLE and any partial word is discarded. Words already written stay in memory.
- Reset values: addr_r=RESET_ADDR, inst=NOP_WORD, inst_valid=0, addr_err=(RESET_ADDR>=DEPTH), ld_ready=0, load_busy=0, load_done=0, state=IDLE.

## Timing
- Fetch latency is 1 cycle: fetch_addr presented at edge N appears on inst after edge N.
- With fetch_en=0, inst stays stable cycle after cycle.
- ld_ready, load_busy and load_done are registered (decoded from state, no combinational path from ld_valid).
- The memory write lands on the edge that accepts the final byte of a word.
- Load of L words takes L*BYTES accepted bytes, then 1 DONE cycle.
- First valid fetch after a load, at RESET_ADDR, appears 2 edges after the last byte: DONE, then IDLE with inst_valid=1.
- Throughput is one byte per cycle when ld_valid is held high.

## Test plan
- Reset: hold rst_n=0, release -> all outputs hold reset values; inst_valid=0 until the first edge after release; inst=NOP_WORD meanwhile.
- Basic load/fetch: load_len=3, bytes 00 00 1d 3c 03 14 00 0c 00 70 bd 37 -> load_done pulses once; fetch addrs 0,1,2 give 3c1d0000, 0c001403, 37bd7000, each one cycle after the address.
- Stall/out of range (DEPTH_LOG2=12):
  - fetch_en=0 while fetch_addr changes -> inst unchanged.
  - fetch_addr=30'h1000 -> inst=NOP_WORD, addr_err=1 the next cycle.
- Handshake gaps: ld_valid toggled randomly through a 2-word load -> memory matches the stream; bytes offered during DONE/IDLE are not consumed; load_start during LOAD is ignored.
- Boundary: load_len=0 -> no state change; load_len=DEPTH+5 -> exactly DEPTH words written, then DONE.
- Reset mid-load: assert rst_n after 6 of 8 bytes of load_len=2 -> word 0 is written, word 1 is unchanged, FSM=IDLE, no load_done pulse.
